// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, addresses InstMem, and loads {pc, inst} into
// the IF/ID register presented to decode over a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [1:0]  state_o
);

    localparam logic [31:0] NopInst = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;

    logic        accept;
    logic        fetch;
    logic [31:0] redirect_aligned;

    assign accept           = !valid_q || out_ready;
    // A halting cycle issues no fetch even though the FSM is still in RUN.
    assign fetch            = (state_q == StRun) && accept && !redirect_valid && !halt_req;
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign inst_addr = WORD_ADDR ? {2'b00, pc_q[31:2]} : pc_q;
    assign out_valid = valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign state_o   = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (start && !halt_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        if (redirect_valid) begin
            // Redirect flushes IF/ID even while decode is stalling it.
            pc_d    = redirect_aligned;
            valid_d = 1'b0;
        end else if (fetch) begin
            pc_d       = pc_q + 32'd4;
            valid_d    = 1'b1;
            out_pc_d   = pc_q;
            out_inst_d = inst;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            out_pc_q   <= 32'h0000_0000;
            out_inst_q <= NopInst;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
        end
    end

endmodule
